// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small byte FIFO in front of the shifter.
// Frames leave back-to-back while bytes are queued; the line idles high.
module uart_tx_fifo #(
    parameter int TICKS_PER_BIT = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          send,
    input  logic [7:0]                    data_in,
    output logic                          bit_out,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          sent,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          ovf_q;

    state_e        state_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          bit_q;
    logic          sent_q;

    logic          push;
    logic          pop;
    logic          tick_last;
    logic [7:0]    head;

    assign full      = (count_q == DEPTH_L);
    assign empty     = (count_q == '0);
    assign level     = count_q;
    assign busy      = (state_q != IDLE);
    assign sent      = sent_q;
    assign overflow  = ovf_q;
    assign bit_out   = bit_q;
    assign head      = mem_q[rd_ptr_q];
    assign tick_last = (tick_q == TICK_LAST);
    assign push      = send && !full;
    // The FSM takes a byte when idle or on the final tick of a stop bit.
    assign pop       = !empty &&
                       ((state_q == IDLE) ||
                        ((state_q == STOP) && tick_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= send && full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            bit_q   <= 1'b1;
            sent_q  <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    bit_q  <= 1'b1;
                    tick_q <= '0;
                    if (pop) begin
                        shift_q <= head;
                        bit_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick_last) begin
                        tick_q  <= '0;
                        idx_q   <= '0;
                        bit_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= DATA;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        tick_q <= '0;
                        if (idx_q == 3'd7) begin
                            bit_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + 3'd1;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_last) begin
                        tick_q <= '0;
                        sent_q <= 1'b1;
                        if (pop) begin
                            shift_q <= head;
                            bit_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    bit_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scoreboard of queued bytes against decoded
// frames, a vector table for FIFO fill/overflow, and timing sequences.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       bit_out, full, empty, busy, sent, overflow;
    logic [2:0] level;

    logic       send2 = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       bit_out2, full2, empty2, busy2, sent2, overflow2;
    logic [2:0] level2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sent_cnt = 0;
    int e0;
    int snap;
    int n;
    bit low_seen;

    logic [7:0] q[$];
    logic [7:0] q2[$];
    int starts[$];
    int starts2[$];
    int sent_at[$];
    bit in_frame = 1'b0;
    bit in_frame2 = 1'b0;

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       acc;
        logic [2:0] lvl;
        logic       f;
        logic       e;
        logic       o;
        logic       b;
    } vec_t;
    vec_t tbl[7];

    uart_tx_fifo #(.TICKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .send(send), .data_in(data_in),
        .bit_out(bit_out), .full(full), .empty(empty), .level(level),
        .busy(busy), .sent(sent), .overflow(overflow)
    );

    uart_tx_fifo #(.TICKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .send(send2), .data_in(data2),
        .bit_out(bit_out2), .full(full2), .empty(empty2), .level(level2),
        .busy(busy2), .sent(sent2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (sent) begin
            sent_cnt++;
            sent_at.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic get_bit(input bit w);
        return w ? bit_out2 : bit_out;
    endfunction

    task automatic mon(input bit w);
        int t;
        logic [7:0] d;
        logic [9:0] fr;
        bit bad;
        bit ab;
        t = w ? 4 : 16;
        forever begin
            @(negedge clk);
            if (rst_n && get_bit(w) == 1'b0) begin
                if (w) begin
                    in_frame2 = 1'b1;
                    starts2.push_back(cyc);
                end else begin
                    in_frame = 1'b1;
                    starts.push_back(cyc);
                end
                d = 8'h00;
                if ((w ? q2.size() : q.size()) == 0) begin
                    chk($sformatf("unexpected_frame_t%0d", t), 1, 0);
                end else if (w) begin
                    d = q2.pop_front();
                end else begin
                    d = q.pop_front();
                end
                fr = {1'b1, d, 1'b0};
                ab = 1'b0;
                for (int b = 0; b < 10 && !ab; b++) begin
                    bad = 1'b0;
                    for (int k = 0; k < t; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (!rst_n) begin
                            ab = 1'b1;
                            break;
                        end
                        if (get_bit(w) !== fr[b]) bad = 1'b1;
                    end
                    if (!ab) begin
                        chk($sformatf("t%0d_byte%02h_bit%0d", t, d, b),
                            {31'd0, bad}, 0);
                    end
                end
                if (w) in_frame2 = 1'b0;
                else in_frame = 1'b0;
            end
        end
    endtask

    initial mon(1'b0);
    initial mon(1'b1);

    task automatic push(input logic [7:0] d);
        send = 1'b1;
        data_in = d;
        q.push_back(d);
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_sent(input int exp, input string nm);
        int k;
        k = 0;
        while (!sent && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk(nm, cyc - e0, exp);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int k;
        k = 0;
        while ((q.size() != 0 || q2.size() != 0 || in_frame ||
                in_frame2 || busy || busy2) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(nm, (k < maxc) ? 1 : 0, 1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'd1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'd2, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 8'd3, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 8'd4, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 8'd5, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 8'd6, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_bit_out", bit_out, 1);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sent", sent, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte 0xA5
        starts.delete();
        push(8'hA5);
        e0 = cyc;
        chk("a5_level_e0", level, 1);
        chk("a5_busy_e0", busy, 0);
        chk("a5_line_e0", bit_out, 1);
        @(negedge clk);
        chk("a5_level_e1", level, 0);
        chk("a5_busy_e1", busy, 1);
        chk("a5_line_e1", bit_out, 0);
        wait_sent(161, "a5_sent_time");
        chk("a5_busy_after", busy, 0);
        @(negedge clk);
        chk("a5_sent_width", sent, 0);
        wait_idle(100, "a5_idle");
        chk("a5_start_lat", (starts.size() > 0) ? starts[0] - e0 : -1, 1);

        // back-to-back frames
        starts.delete();
        sent_at.delete();
        push(8'h00);
        e0 = cyc;
        push(8'hFF);
        push(8'h3C);
        chk("b2b_level", level, 2);
        n = 0;
        while (sent_at.size() < 3 && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_sent_count", sent_at.size(), 3);
        for (int i = 0; i < sent_at.size() && i < 3; i++) begin
            chk($sformatf("b2b_sent%0d", i), sent_at[i] - e0, 161 + 160 * i);
        end
        for (int i = 1; i < starts.size() && i < 3; i++) begin
            chk($sformatf("b2b_gap%0d", i), starts[i] - starts[i-1], 160);
        end
        chk("b2b_empty", empty, 1);
        wait_idle(100, "b2b_idle");

        // FIFO fill and overflow, table driven
        snap = sent_cnt;
        for (int i = 0; i < 7; i++) begin
            send = tbl[i].s;
            data_in = tbl[i].d;
            if (tbl[i].acc) q.push_back(tbl[i].d);
            @(negedge clk);
            chk($sformatf("ovf%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("ovf%0d_full", i), full, tbl[i].f);
            chk($sformatf("ovf%0d_empty", i), empty, tbl[i].e);
            chk($sformatf("ovf%0d_overflow", i), overflow, tbl[i].o);
            chk($sformatf("ovf%0d_busy", i), busy, tbl[i].b);
        end
        send = 1'b0;
        wait_idle(1200, "ovf_idle");
        chk("ovf_frames", sent_cnt - snap, 5);

        // reset during data bit 3 with two bytes queued
        push(8'hAA);
        e0 = cyc;
        push(8'hBB);
        push(8'hCC);
        chk("rst_mid_level", level, 2);
        while (cyc - e0 < 70) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        snap = sent_cnt;
        chk("rst_mid_line", bit_out, 1);
        chk("rst_mid_level0", level, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_empty", empty, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        low_seen = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (bit_out !== 1'b1) low_seen = 1'b1;
        end
        chk("rst_mid_no_sent", sent_cnt - snap, 0);
        chk("rst_mid_line_idle", low_seen, 0);
        chk("rst_mid_busy_after", busy, 0);

        // TICKS_PER_BIT = 4
        starts2.delete();
        send2 = 1'b1;
        data2 = 8'h81;
        q2.push_back(8'h81);
        @(negedge clk);
        send2 = 1'b0;
        e0 = cyc;
        n = 0;
        while (!sent2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_sent_time", cyc - e0, 41);
        chk("t4_busy_after", busy2, 0);
        chk("t4_start_lat", (starts2.size() > 0) ? starts2[0] - e0 : -1, 1);
        wait_idle(100, "t4_idle");

        // push during the stop bit with the FIFO empty
        starts.delete();
        push(8'h11);
        e0 = cyc;
        while (cyc - e0 < 150) @(negedge clk);
        chk("stop_empty_before", empty, 1);
        push(8'h55);
        chk("stop_level", level, 1);
        chk("stop_busy", busy, 1);
        wait_sent(161, "stop_sent_time");
        chk("stop_busy_cont", busy, 1);
        chk("stop_line_start", bit_out, 0);
        wait_idle(300, "stop_idle");
        chk("stop_gap", (starts.size() > 1) ? starts[1] - starts[0] : -1, 160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
